// File: rtl/cam_capture.sv
// cam_capture: camera byte stream to frame buffer writer (RGB444 / greyscale)
module cam_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FRAME_SKIP = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_mode,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic [18:0] o_waddr,
  output logic [11:0] o_wdata,
  output logic        o_wr,
  output logic        o_frame_done,
  output logic        o_overflow
);
  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int RW = $clog2(V_ACTIVE + 1);
  localparam logic [18:0] LAST = 19'(H_ACTIVE * V_ACTIVE - 1);
  typedef enum logic [1:0] {SKIP, WAIT_FRAME, CAPTURE} state_t;
  state_t state, state_nx;
  logic vs_r, vs_d, hr_r, hr_d, phase, mode_q, done_nx;
  logic [7:0] d_r, first, skip_cnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [18:0] line_base;
  logic vs_fall, vs_rise, hr_fall, pix_done, in_win;
  assign vs_fall  = vs_d & ~vs_r;
  assign vs_rise  = ~vs_d & vs_r;
  assign hr_fall  = hr_d & ~hr_r;
  assign pix_done = hr_r & phase & (state == CAPTURE);
  assign in_win   = (col < CW'(H_ACTIVE)) && (row < RW'(V_ACTIVE));
  // input registers and delayed copies used for edge detection
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      vs_r <= 1'b0;
      vs_d <= 1'b0;
      hr_r <= 1'b0;
      hr_d <= 1'b0;
      d_r  <= '0;
    end else begin
      vs_r <= i_vsync;
      vs_d <= vs_r;
      hr_r <= i_href;
      hr_d <= hr_r;
      d_r  <= i_data;
    end
  // state register
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) state <= SKIP;
    else state <= state_nx;
  // next-state and end-of-frame pulse request
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      SKIP:       if (skip_cnt >= 8'(FRAME_SKIP)) state_nx = WAIT_FRAME;
      WAIT_FRAME: if (vs_fall) state_nx = CAPTURE;
      CAPTURE:    if (vs_rise) begin
        state_nx = WAIT_FRAME;
        done_nx  = 1'b1;
      end
      default:    state_nx = SKIP;
    endcase
  end
  // pixel assembly, addressing, write strobe and status flags
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      skip_cnt     <= '0;
      phase        <= 1'b0;
      first        <= '0;
      mode_q       <= 1'b0;
      col          <= '0;
      row          <= '0;
      line_base    <= '0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_wr         <= 1'b0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      if (state == SKIP && vs_fall) skip_cnt <= skip_cnt + 1'b1;
      phase <= hr_r ? ~phase : 1'b0;
      if (hr_r && !phase) first <= d_r;
      if (state == WAIT_FRAME && vs_fall) mode_q <= i_mode;
      o_wr         <= pix_done && in_win;
      o_frame_done <= done_nx;
      if (pix_done && !in_win) o_overflow <= 1'b1;
      if (pix_done && in_win) o_wdata <= mode_q ? {4'h0, first} : {first[3:0], d_r};
      if (state != CAPTURE) begin
        col       <= '0;
        row       <= '0;
        line_base <= '0;
        o_waddr   <= '0;
      end else if (hr_fall) begin
        col <= '0;
        if (row < RW'(V_ACTIVE)) row <= row + 1'b1;
        if (row < RW'(V_ACTIVE - 1)) begin
          line_base <= line_base + 19'(H_ACTIVE);
          o_waddr   <= line_base + 19'(H_ACTIVE);
        end
      end else begin
        if (pix_done && col < CW'(H_ACTIVE)) col <= col + 1'b1;
        if (o_wr && o_waddr != LAST) o_waddr <= o_waddr + 1'b1;
      end
    end
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed self-checking bench for cam_capture (8x4 window)
module tb_cam_capture;
  localparam int H = 8, V = 4;
  logic clk = 1'b0, rstn = 1'b0, mode = 1'b0, vs = 1'b1, hr = 1'b0;
  logic [7:0] d = '0;
  logic [18:0] waddr;
  logic [11:0] wdata;
  logic wr, fd, ovf;
  int checks = 0, errors = 0, n_fd = 0;
  logic [18:0] wa[$];
  logic [11:0] wd[$];

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_SKIP(2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_mode(mode), .i_vsync(vs), .i_href(hr), .i_data(d),
    .o_waddr(waddr), .o_wdata(wdata), .o_wr(wr), .o_frame_done(fd), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr) begin
      wa.push_back(waddr);
      wd.push_back(wdata);
    end
    if (fd) n_fd++;
  end

  function automatic logic [11:0] pix(input int r, input int c);
    return {4'(r), 4'(c), 4'(r + c + 3)};
  endfunction

  task automatic drive(input logic v, input logic h, input logic [7:0] b);
    @(negedge clk);
    vs = v; hr = h; d = b;
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) drive(v, 1'b0, 8'h00);
  endtask

  task automatic start_frame;
    idle(3, 1'b1);
    idle(3, 1'b0);
  endtask

  task automatic end_frame;
    idle(3, 1'b0);
    idle(4, 1'b1);
  endtask

  task automatic rgb_line(input int r, input int n, input bit odd);
    logic [11:0] p;
    for (int c = 0; c < n; c++) begin
      p = pix(r, c);
      drive(1'b0, 1'b1, {4'hF, p[11:8]});
      drive(1'b0, 1'b1, p[7:0]);
    end
    if (odd) drive(1'b0, 1'b1, 8'hEE);
    idle(3, 1'b0);
  endtask

  task automatic rgb_frame(input int lines);
    start_frame;
    for (int r = 0; r < lines; r++) rgb_line(r, H, 1'b0);
    end_frame;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0h want 0", wr); end
    checks++; if (waddr !== 19'd0) begin errors++; $display("FAIL reset_waddr got %0h want 0", waddr); end
    checks++; if (wdata !== 12'd0) begin errors++; $display("FAIL reset_wdata got %0h want 0", wdata); end
    checks++; if (fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0h want 0", fd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0h want 0", ovf); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_skip_frames;
    int bad;
    rgb_frame(V);
    rgb_frame(V);
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL skip_writes got %0d want 0", wa.size()); end
    checks++; if (n_fd != 0) begin errors++; $display("FAIL skip_frame_done got %0d want 0", n_fd); end
    rgb_frame(V);
    checks++; if (wa.size() != H * V) begin errors++; $display("FAIL frame3_writes got %0d want %0d", wa.size(), H * V); end
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 19'(i) || wd[i] !== pix(i / H, i % H)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL frame3_content got %0d bad want 0", bad); end
    checks++; if (n_fd != 1) begin errors++; $display("FAIL frame3_frame_done got %0d want 1", n_fd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL frame3_overflow got %0h want 0", ovf); end
  endtask

  task automatic test_latency;
    int fd0;
    fd0 = n_fd;
    wa.delete(); wd.delete();
    start_frame;
    drive(1'b0, 1'b1, 8'h0A);
    drive(1'b0, 1'b1, 8'h5C);
    drive(1'b0, 1'b0, 8'h00);
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL lat_early_wr got %0h want 0", wr); end
    drive(1'b0, 1'b0, 8'h00);
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL lat_wr got %0h want 1", wr); end
    checks++; if (waddr !== 19'd0) begin errors++; $display("FAIL lat_waddr got %0h want 0", waddr); end
    checks++; if (wdata !== 12'hA5C) begin errors++; $display("FAIL lat_wdata got %0h want a5c", wdata); end
    drive(1'b0, 1'b0, 8'h00);
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL lat_wr_single got %0h want 0", wr); end
    end_frame;
    checks++; if (n_fd != fd0 + 1) begin errors++; $display("FAIL lat_frame_done got %0d want %0d", n_fd, fd0 + 1); end
  endtask

  task automatic test_grey;
    wa.delete(); wd.delete();
    mode = 1'b1;
    start_frame;
    drive(1'b0, 1'b1, 8'h80);
    drive(1'b0, 1'b1, 8'h33);
    drive(1'b0, 1'b1, 8'h12);
    drive(1'b0, 1'b1, 8'hFF);
    mode = 1'b0;
    drive(1'b0, 1'b1, 8'h45);
    drive(1'b0, 1'b1, 8'h99);
    end_frame;
    checks++; if (wa.size() != 3) begin errors++; $display("FAIL grey_writes got %0d want 3", wa.size()); end
    else begin
      checks++; if (wd[0] !== 12'h080) begin errors++; $display("FAIL grey_y0 got %0h want 080", wd[0]); end
      checks++; if (wd[1] !== 12'h012) begin errors++; $display("FAIL grey_y1 got %0h want 012", wd[1]); end
      checks++; if (wd[2] !== 12'h045) begin errors++; $display("FAIL grey_mode_hold got %0h want 045", wd[2]); end
      checks++; if (wa[2] !== 19'd2) begin errors++; $display("FAIL grey_addr got %0h want 2", wa[2]); end
    end
  endtask

  task automatic test_overflow;
    wa.delete(); wd.delete();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0h want 0", ovf); end
    start_frame;
    rgb_line(0, H + 2, 1'b0);
    checks++; if (wa.size() != H) begin errors++; $display("FAIL ovf_line_writes got %0d want %0d", wa.size(), H); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h want 1", ovf); end
    rgb_line(1, H, 1'b0);
    checks++; if (wa.size() != 2 * H) begin errors++; $display("FAIL ovf_next_writes got %0d want %0d", wa.size(), 2 * H); end
    else begin
      checks++; if (wa[H] !== 19'(H)) begin errors++; $display("FAIL ovf_next_addr got %0h want %0h", wa[H], H); end
      checks++; if (wd[H] !== pix(1, 0)) begin errors++; $display("FAIL ovf_next_data got %0h want %0h", wd[H], pix(1, 0)); end
    end
    end_frame;
  endtask

  task automatic test_short_line;
    wa.delete(); wd.delete();
    start_frame;
    rgb_line(0, 3, 1'b1);
    checks++; if (wa.size() != 3) begin errors++; $display("FAIL short_odd_writes got %0d want 3", wa.size()); end
    rgb_line(1, H, 1'b0);
    checks++; if (wa.size() != 3 + H) begin errors++; $display("FAIL short_total got %0d want %0d", wa.size(), 3 + H); end
    else begin
      checks++; if (wa[3] !== 19'(H)) begin errors++; $display("FAIL short_align got %0h want %0h", wa[3], H); end
      checks++; if (wd[2] !== pix(0, 2)) begin errors++; $display("FAIL short_last_data got %0h want %0h", wd[2], pix(0, 2)); end
    end
    end_frame;
  endtask

  task automatic test_rows;
    logic [18:0] mx;
    wa.delete(); wd.delete();
    start_frame;
    for (int r = 0; r < V + 1; r++) rgb_line(r, H, 1'b0);
    end_frame;
    mx = '0;
    foreach (wa[i]) if (wa[i] > mx) mx = wa[i];
    checks++; if (wa.size() != H * V) begin errors++; $display("FAIL rows_writes got %0d want %0d", wa.size(), H * V); end
    checks++; if (mx !== 19'(H * V - 1)) begin errors++; $display("FAIL rows_max_addr got %0h want %0h", mx, H * V - 1); end
  endtask

  task automatic test_vsync_coincide;
    int fd0;
    logic [11:0] p;
    fd0 = n_fd;
    wa.delete(); wd.delete();
    start_frame;
    rgb_line(0, 2, 1'b0);
    p = pix(1, 0);
    drive(1'b0, 1'b1, {4'hF, p[11:8]});
    drive(1'b1, 1'b1, p[7:0]);
    idle(6, 1'b1);
    checks++; if (wa.size() != 3) begin errors++; $display("FAIL coin_writes got %0d want 3", wa.size()); end
    else begin
      checks++; if (wa[2] !== 19'(H)) begin errors++; $display("FAIL coin_addr got %0h want %0h", wa[2], H); end
      checks++; if (wd[2] !== p) begin errors++; $display("FAIL coin_data got %0h want %0h", wd[2], p); end
    end
    checks++; if (n_fd != fd0 + 1) begin errors++; $display("FAIL coin_frame_done got %0d want %0d", n_fd, fd0 + 1); end
  endtask

  task automatic test_reset_mid;
    int sz;
    wa.delete(); wd.delete();
    start_frame;
    for (int r = 0; r < 2; r++) rgb_line(r, H, 1'b0);
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h02);
    drive(1'b0, 1'b1, 8'h03);
    #2 rstn = 1'b0;
    #1;
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rmid_wr got %0h want 0", wr); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %0h want 0", ovf); end
    checks++; if (waddr !== 19'd0) begin errors++; $display("FAIL rmid_waddr got %0h want 0", waddr); end
    sz = wa.size();
    drive(1'b0, 1'b1, 8'h04);
    drive(1'b0, 1'b1, 8'h05);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'(i));
    idle(3, 1'b0);
    rgb_line(3, H, 1'b0);
    end_frame;
    rgb_frame(V);
    rgb_frame(V);
    checks++; if (wa.size() != sz) begin errors++; $display("FAIL rmid_skip got %0d want %0d", wa.size(), sz); end
    rgb_frame(V);
    checks++; if (wa.size() != sz + H * V) begin errors++; $display("FAIL rmid_resume got %0d want %0d", wa.size(), sz + H * V); end
    else begin
      checks++; if (wa[sz] !== 19'd0) begin errors++; $display("FAIL rmid_first_addr got %0h want 0", wa[sz]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_skip_frames;
    test_latency;
    test_grey;
    test_overflow;
    test_short_line;
    test_rows;
    test_vsync_coincide;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
